// File: rtl/conv_weight_bank_if.sv
// Bundle for conv_weight_bank: write port, stream request and the valid/ready weight stream.
// The slave modport is the weight bank, the master modport is whoever loads it and consumes the stream.
interface conv_weight_bank_if #(
  parameter int WIDTH       = 32,
  parameter int KERNEL_SIZE = 3,
  parameter int SET_NUM     = 4
);
  localparam int KK    = KERNEL_SIZE * KERNEL_SIZE;
  localparam int SET_W = (SET_NUM > 1) ? $clog2(SET_NUM) : 1;
  localparam int IDX_W = $clog2(KK + 1);

  logic             i_wr_en;
  logic [SET_W-1:0] i_wr_set;
  logic [IDX_W-1:0] i_wr_idx;
  logic [WIDTH-1:0] i_wr_data;
  logic             i_start;
  logic [SET_W-1:0] i_set;
  logic             i_ready;
  logic [WIDTH-1:0] o_weight;
  logic             o_valid;
  logic             o_is_bias;
  logic             o_last;
  logic             o_busy;
  logic             o_err;

  modport slave (
    input  i_wr_en, i_wr_set, i_wr_idx, i_wr_data, i_start, i_set, i_ready,
    output o_weight, o_valid, o_is_bias, o_last, o_busy, o_err
  );

  modport master (
    output i_wr_en, i_wr_set, i_wr_idx, i_wr_data, i_start, i_set, i_ready,
    input  o_weight, o_valid, o_is_bias, o_last, o_busy, o_err
  );
endinterface

// File: rtl/conv_weight_bank.sv
// Run-time loadable multi-set kernel store that streams one set (row-major weights, then bias).
// Optional feature: define CONV_WEIGHT_PARITY_EN to store an even-parity bit per word and flag corrupt reads.
module conv_weight_bank #(
  parameter int WIDTH       = 32,
  parameter int KERNEL_SIZE = 3,
  parameter int SET_NUM     = 4
) (
  input logic                clk,
  input logic                rst,
  conv_weight_bank_if.slave  bus
);
  localparam int KK     = KERNEL_SIZE * KERNEL_SIZE;
  localparam int SET_W  = (SET_NUM > 1) ? $clog2(SET_NUM) : 1;
  localparam int IDX_W  = $clog2(KK + 1);
  localparam int DEPTH  = SET_NUM * (KK + 1);
  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_WGT, ST_BIAS} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [SET_W-1:0] r_set;
  logic [IDX_W-1:0] r_ptr;
  logic [WIDTH-1:0] r_weight;
  logic             r_err;
  logic [WIDTH-1:0] r_mem [DEPTH];

  logic              w_busy;
  logic              w_hs;
  logic              w_set_ok;
  logic              w_start_ok;
  logic              w_start_bad;
  logic              w_wr_range_ok;
  logic              w_wr_conflict;
  logic              w_wr_ok;
  logic              w_wr_bad;
  logic              w_load;
  logic [SET_W-1:0]  w_rd_set;
  logic [IDX_W-1:0]  w_rd_idx;
  logic [ADDR_W-1:0] w_rd_addr;
  logic [ADDR_W-1:0] w_wr_addr;

  assign w_busy      = (r_state != ST_IDLE);
  assign w_hs        = w_busy & bus.i_ready;
  assign w_set_ok    = ({1'b0, bus.i_set} < (SET_W+1)'(SET_NUM));
  assign w_start_ok  = bus.i_start & ~w_busy & w_set_ok;
  assign w_start_bad = bus.i_start & ~w_busy & ~w_set_ok;

  // The streaming set is write-protected, and a start on the same set beats a simultaneous write.
  assign w_wr_range_ok = ({1'b0, bus.i_wr_set} < (SET_W+1)'(SET_NUM)) &&
                         (bus.i_wr_idx <= IDX_W'(KK));
  assign w_wr_conflict = (w_busy && (bus.i_wr_set == r_set)) ||
                         (w_start_ok && (bus.i_wr_set == bus.i_set));
  assign w_wr_ok       = bus.i_wr_en & w_wr_range_ok & ~w_wr_conflict;
  assign w_wr_bad      = bus.i_wr_en & ~w_wr_ok;

  assign w_load    = w_start_ok | (w_hs & (r_state == ST_WGT));
  assign w_rd_set  = w_busy ? r_set : bus.i_set;
  assign w_rd_idx  = w_busy ? (r_ptr + IDX_W'(1)) : '0;
  assign w_rd_addr = ADDR_W'(w_rd_set) * ADDR_W'(KK + 1) + ADDR_W'(w_rd_idx);
  assign w_wr_addr = ADDR_W'(bus.i_wr_set) * ADDR_W'(KK + 1) + ADDR_W'(bus.i_wr_idx);

  always_ff @(posedge clk) begin
    if (w_wr_ok) r_mem[w_wr_addr] <= bus.i_wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_start_ok) w_next = ST_WGT;
      ST_WGT:  if (bus.i_ready && (r_ptr == IDX_W'(KK - 1))) w_next = ST_BIAS;
      ST_BIAS: if (bus.i_ready) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // The next word is fetched on the same edge that consumes the current one, so the stream has no gaps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_set    <= '0;
      r_ptr    <= '0;
      r_weight <= '0;
      r_err    <= 1'b0;
    end else begin
      r_err <= w_start_bad | w_wr_bad;
      if (w_start_ok) begin
        r_set <= bus.i_set;
        r_ptr <= '0;
      end else if (w_hs) begin
        r_ptr <= (r_state == ST_BIAS) ? '0 : w_rd_idx;
      end
      if (w_load) r_weight <= r_mem[w_rd_addr];
    end
  end

`ifdef CONV_WEIGHT_PARITY_EN
  logic r_par [DEPTH];
  logic r_par_err;

  always_ff @(posedge clk) begin
    if (w_wr_ok) r_par[w_wr_addr] <= ^bus.i_wr_data;
  end

  // Flag lands in the first cycle the corrupt word is presented.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_par_err <= 1'b0;
    else     r_par_err <= w_load && ((^r_mem[w_rd_addr]) != r_par[w_rd_addr]);
  end
`endif

  always_comb begin
    bus.o_valid   = w_busy;
    bus.o_busy    = w_busy;
    bus.o_is_bias = (r_state == ST_BIAS);
    bus.o_last    = (r_state == ST_BIAS);
    bus.o_weight  = r_weight;
`ifdef CONV_WEIGHT_PARITY_EN
    bus.o_err     = r_err | r_par_err;
`else
    bus.o_err     = r_err;
`endif
  end
endmodule

// File: tb/tb_conv_weight_bank.sv
// Self-checking bench for conv_weight_bank: scoreboard of expected stream words popped on every handshake.
// SET_NUM is 5 here so that an out-of-range set index is encodable on the 3-bit set ports.
module tb_conv_weight_bank;
  localparam int WIDTH       = 32;
  localparam int KERNEL_SIZE = 3;
  localparam int NSET        = 5;
  localparam int KK          = KERNEL_SIZE * KERNEL_SIZE;
  localparam int SET_W       = $clog2(NSET);
  localparam int IDX_W       = $clog2(KK + 1);

  typedef struct {
    logic [31:0] w;
    logic        b;
  } exp_t;

  logic clk;
  logic rst;
  int   nCompared;
  int   nMismatched;
  logic [31:0] model [NSET][KK+1];
  exp_t sb[$];

  conv_weight_bank_if #(.WIDTH(WIDTH), .KERNEL_SIZE(KERNEL_SIZE), .SET_NUM(NSET)) bus ();

  conv_weight_bank #(.WIDTH(WIDTH), .KERNEL_SIZE(KERNEL_SIZE), .SET_NUM(NSET)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    nCompared++;
    if (obs !== expv) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic pushSet(input int s);
    exp_t e;
    for (int i = 0; i <= KK; i++) begin
      e.w = model[s][i];
      e.b = (i == KK);
      sb.push_back(e);
    end
  endtask

  task automatic writeWord(input int s, input int idx, input logic [31:0] d, input logic expErr,
                           input string tag);
    @(posedge clk); #1;
    bus.i_wr_en   = 1'b1;
    bus.i_wr_set  = SET_W'(s);
    bus.i_wr_idx  = IDX_W'(idx);
    bus.i_wr_data = d;
    @(posedge clk); #1;
    bus.i_wr_en = 1'b0;
    @(negedge clk);
    checkOutput(tag, {31'd0, bus.o_err}, {31'd0, expErr});
    if (!expErr) model[s][idx] = d;
  endtask

  // Pulse i_start right now (caller is just past an edge) and return just past the accepting edge.
  task automatic pulseStart(input int s);
    bus.i_start = 1'b1;
    bus.i_set   = SET_W'(s);
    if (s < NSET) pushSet(s);
    @(posedge clk); #1;
    bus.i_start = 1'b0;
  endtask

  task automatic applyStimulus(input int s);
    @(posedge clk); #1;
    pulseStart(s);
  endtask

  task automatic waitIdle(input string tag);
    int n;
    n = 0;
    while (bus.o_busy === 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput({tag, " idle"}, {31'd0, bus.o_busy}, 32'd0);
    checkOutput({tag, " sb drained"}, sb.size(), 32'd0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus.o_valid && bus.i_ready) begin
      if (sb.size() == 0) begin
        checkOutput("sb underflow", sb.size(), 32'd1);
      end else begin
        e = sb.pop_front();
        checkOutput("stream weight", bus.o_weight, e.w);
        checkOutput("stream is_bias", {31'd0, bus.o_is_bias}, {31'd0, e.b});
        checkOutput("stream last", {31'd0, bus.o_last}, {31'd0, e.b});
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    nCompared   = 0;
    nMismatched = 0;
    rst = 1'b0;
    bus.i_wr_en = 1'b0; bus.i_wr_set = '0; bus.i_wr_idx = '0; bus.i_wr_data = '0;
    bus.i_start = 1'b0; bus.i_set = '0; bus.i_ready = 1'b1;

    #2 rst = 1'b1;
    #1;
    checkOutput("reset valid", {31'd0, bus.o_valid}, 32'd0);
    checkOutput("reset busy", {31'd0, bus.o_busy}, 32'd0);
    checkOutput("reset err", {31'd0, bus.o_err}, 32'd0);
    checkOutput("reset last", {31'd0, bus.o_last}, 32'd0);
    checkOutput("reset is_bias", {31'd0, bus.o_is_bias}, 32'd0);
    checkOutput("reset weight", bus.o_weight, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i <= KK; i++) writeWord(0, i, (i == KK) ? 32'd100 : 32'(i + 1), 1'b0, "load set0");
    for (int s = 1; s < 4; s++)
      for (int i = 0; i <= KK; i++) writeWord(s, i, 32'(s * 32'h1100 + i), 1'b0, "load set");

    $display("[TB] T1 back-to-back stream of set 0");
    applyStimulus(0);
    checkOutput("T1 first valid", {31'd0, bus.o_valid}, 32'd1);
    checkOutput("T1 first word", bus.o_weight, 32'd1);
    repeat (KK) @(posedge clk);
    #1;
    checkOutput("T1 bias on cycle 10", bus.o_weight, 32'd100);
    checkOutput("T1 last on bias", {31'd0, bus.o_last}, 32'd1);
    @(posedge clk); #1;
    checkOutput("T1 busy falls", {31'd0, bus.o_busy}, 32'd0);
    checkOutput("T1 valid falls", {31'd0, bus.o_valid}, 32'd0);
    checkOutput("T1 sb drained", sb.size(), 32'd0);

    $display("[TB] T2 stall on word 3");
    applyStimulus(0);
    repeat (2) @(posedge clk);
    #1 bus.i_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput("T2 held word", bus.o_weight, 32'd3);
      checkOutput("T2 held valid", {31'd0, bus.o_valid}, 32'd1);
      @(posedge clk); #1;
    end
    bus.i_ready = 1'b1;
    waitIdle("T2");

    $display("[TB] T3 set 3 then set 1 with one bubble");
    applyStimulus(3);
    repeat (KK + 1) @(posedge clk);
    #1;
    checkOutput("T3 bubble valid", {31'd0, bus.o_valid}, 32'd0);
    pulseStart(1);
    checkOutput("T3 second valid", {31'd0, bus.o_valid}, 32'd1);
    waitIdle("T3");

    $display("[TB] T4 write protect of the active set");
    applyStimulus(2);
    writeWord(2, 0, 32'hDEAD, 1'b1, "T4 protect err");
    checkOutput("T4 still busy", {31'd0, bus.o_busy}, 32'd1);
    writeWord(1, 4, 32'h1234, 1'b0, "T4 other set ok");
    waitIdle("T4a");
    applyStimulus(2);
    waitIdle("T4b");
    applyStimulus(1);
    waitIdle("T4c");

    $display("[TB] T5 range errors and start/write collision");
    @(posedge clk); #1;
    bus.i_start = 1'b1; bus.i_set = SET_W'(NSET);
    @(posedge clk); #1;
    bus.i_start = 1'b0;
    checkOutput("T5 bad start err", {31'd0, bus.o_err}, 32'd1);
    checkOutput("T5 bad start busy", {31'd0, bus.o_busy}, 32'd0);
    @(posedge clk); #1;
    checkOutput("T5 err one cycle", {31'd0, bus.o_err}, 32'd0);
    writeWord(0, KK + 1, 32'hBAD, 1'b1, "T5 bad idx err");
    writeWord(7, 0, 32'hBAD, 1'b1, "T5 bad set err");
    applyStimulus(1);
    waitIdle("T5a");
    @(posedge clk); #1;
    bus.i_wr_en = 1'b1; bus.i_wr_set = '0; bus.i_wr_idx = '0; bus.i_wr_data = 32'hBEEF;
    pulseStart(0);
    bus.i_wr_en = 1'b0;
    checkOutput("T5 collide err", {31'd0, bus.o_err}, 32'd1);
    waitIdle("T5b");
    applyStimulus(0);
    waitIdle("T5c");

    $display("[TB] T6 reset mid-stream");
    applyStimulus(1);
    repeat (5) @(posedge clk);
    #1;
    checkOutput("T6 word5", bus.o_weight, model[1][5]);
    rst = 1'b1;
    #1;
    checkOutput("T6 async valid", {31'd0, bus.o_valid}, 32'd0);
    checkOutput("T6 async busy", {31'd0, bus.o_busy}, 32'd0);
    sb.delete();
    @(posedge clk); #1 rst = 1'b0;
    applyStimulus(1);
    checkOutput("T6 restart word0", bus.o_weight, model[1][0]);
    waitIdle("T6");

`ifdef CONV_WEIGHT_PARITY_EN
    $display("[TB] T6p corrupted stored word");
    force dut.r_mem[2] = 32'd2;
    applyStimulus(0);
    sb[2].w = 32'd2;
    for (int k = 0; k <= KK; k++) begin
      @(negedge clk);
      checkOutput($sformatf("T6p err word %0d", k), {31'd0, bus.o_err}, (k == 2) ? 32'd1 : 32'd0);
    end
    release dut.r_mem[2];
    waitIdle("T6p");
    writeWord(0, 2, 32'd3, 1'b0, "T6p restore");
`endif

    checkOutput("final sb empty", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end
endmodule
